// File: rtl/seq_det_ctrl.sv
//==============================================================================
// Module   : seq_det_ctrl
// Purpose  : Word-level sequencing controller around a serial 1011 detector.
//            Define SEQ_DET_CTRL_NONOV_EN for non-overlapping detection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_det_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       det_state
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RUN  = 2'd1,
        C_DONE = 2'd2
    } ctrl_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_e;

    ctrl_e             ctrl_q, ctrl_d;
    det_e              det_q,  det_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [WIDTH-1:0]  din_q,  din_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              w_bit;
    det_e              w_det_nxt;

    function automatic det_e det_next(input det_e s, input logic b);
        det_e n;
        n = S0;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S1 : S2;
            S2:      n = b ? S3 : S0;
            S3:      n = b ? S4 : S2;
`ifdef SEQ_DET_CTRL_NONOV_EN
            S4:      n = b ? S1 : S0;
`else
            S4:      n = b ? S1 : S2;
`endif
            default: n = S0;
        endcase
        return n;
    endfunction

    always_comb begin
        ctrl_d    = ctrl_q;
        det_d     = det_q;
        idx_d     = idx_q;
        din_d     = din_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        w_bit     = din_q[idx_q];
        w_det_nxt = det_next(det_q, w_bit);

        case (ctrl_q)
            C_IDLE: begin
                // abort outranks start, so a simultaneous request is dropped
                if (start && !abort) begin
                    din_d  = din;
                    dout_d = '0;
                    cnt_d  = '0;
                    det_d  = S0;
                    idx_d  = IDX_W'(WIDTH - 1);
                    ctrl_d = C_RUN;
                end
            end
            C_RUN: begin
                if (abort) begin
                    det_d  = S0;
                    idx_d  = IDX_W'(WIDTH - 1);
                    ctrl_d = C_IDLE;
                end else begin
                    det_d = w_det_nxt;
                    if (w_det_nxt == S4) begin
                        dout_d[idx_q] = 1'b1;
                        cnt_d         = cnt_q + CNT_W'(1);
                    end
                    if (idx_q == '0) begin
                        ctrl_d = C_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            C_DONE: begin
                ctrl_d = C_IDLE;
            end
            default: begin
                ctrl_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= C_IDLE;
            det_q  <= S0;
            idx_q  <= IDX_W'(WIDTH - 1);
            din_q  <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            det_q  <= det_d;
            idx_q  <= idx_d;
            din_q  <= din_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy      = (ctrl_q != C_IDLE);
    assign done      = (ctrl_q == C_DONE);
    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign det_state = det_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
//==============================================================================
// Module   : tb_seq_det_ctrl
// Purpose  : Scoreboard bench for seq_det_ctrl (WIDTH=32); honours
//            SEQ_DET_CTRL_NONOV_EN for the expected detection mode.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_det_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       st;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0]       det_state;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   n_jobs = 0;

    seq_det_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .dout      (dout),
        .match_cnt (match_cnt),
        .det_state (det_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] d, input int c, input logic [2:0] s);
        exp_t e;
        e.dout = d;
        e.cnt  = CNT_W'(c);
        e.st   = s;
        return e;
    endfunction

    // Reference detector walked MSB first over the whole word
    function automatic exp_t model(input logic [WIDTH-1:0] d);
        exp_t       e;
        logic [2:0] s;
        logic [2:0] n;
        e = '0;
        s = 3'd0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            case (s)
                3'd0: n = d[k] ? 3'd1 : 3'd0;
                3'd1: n = d[k] ? 3'd1 : 3'd2;
                3'd2: n = d[k] ? 3'd3 : 3'd0;
                3'd3: n = d[k] ? 3'd4 : 3'd2;
`ifdef SEQ_DET_CTRL_NONOV_EN
                default: n = d[k] ? 3'd1 : 3'd0;
`else
                default: n = d[k] ? 3'd1 : 3'd2;
`endif
            endcase
            if (n == 3'd4) begin
                e.dout[k] = 1'b1;
                e.cnt     = e.cnt + CNT_W'(1);
            end
            s = n;
        end
        e.st = s;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", 64'(dout), 64'(e.dout));
                chk("match_cnt", 64'(match_cnt), 64'(e.cnt));
                chk("det_state", 64'(det_state), 64'(e.st));
                n_done++;
            end
        end
    end

    task automatic launch(input logic [WIDTH-1:0] d, input bit push, input exp_t e);
        @(negedge clk);
        din   = d;
        start = 1'b1;
        if (push) begin
            sb.push_back(e);
            n_jobs++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~d;
        chk("busy_on_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < WIDTH + 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(WIDTH));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run_job(input logic [WIDTH-1:0] d, input exp_t e);
        launch(d, 1'b1, e);
        wait_done();
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_cnt", 64'(match_cnt), 64'd0);
        chk("rst_state", 64'(det_state), 64'd0);
        rst_n = 1'b1;

        run_job(32'hB000_0000, mk(32'h1000_0000, 1, 3'd0));
`ifdef SEQ_DET_CTRL_NONOV_EN
        run_job(32'hB600_0000, mk(32'h1000_0000, 1, 3'd0));
`else
        run_job(32'hB600_0000, mk(32'h1200_0000, 2, 3'd0));
`endif
        run_job(32'hBBBB_BBBB, mk(32'h1111_1111, 8, 3'd4));
        run_job(32'hFFFF_FFFF, mk(32'h0000_0000, 0, 3'd1));
        run_job(32'hB6D6_B5AD, model(32'hB6D6_B5AD));

        // Abort mid-job, with an ignored start issued while busy
        launch(32'hB000_000B, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dout", 64'(dout), 64'h1000_0000);
        chk("abort_cnt", 64'(match_cnt), 64'd1);
        chk("abort_state", 64'(det_state), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_stays_idle", 64'(busy), 64'd0);

        // start together with abort in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        din   = 32'h0000_000B;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        chk("start_abort_dout", 64'(dout), 64'h1000_0000);

        run_job(32'hB000_000B, mk(32'h1000_0001, 2, 3'd4));

        // Reset asserted in the middle of a job
        launch(32'hBBBB_BBBB, 1'b0, '0);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_dout", 64'(dout), 64'd0);
        chk("midrst_cnt", 64'(match_cnt), 64'd0);
        chk("midrst_state", 64'(det_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(32'hB000_0000, mk(32'h1000_0000, 1, 3'd0));

        for (int i = 0; i < 4; i++) begin
            r = WIDTH'($urandom);
            run_job(r, model(r));
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("jobs_done", 64'(n_done), 64'(n_jobs));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
